// File: rtl/psram_pkg.sv
// Shared types and constants for the three-port PSRAM arbiter and its controller.
package psram_pkg;

    localparam int         PSRAM_PORTS = 3;
    localparam logic [1:0] GRANT_NONE  = 2'd3;

    typedef enum logic [2:0] {
        ARB_INIT     = 3'd0,
        ARB_IDLE     = 3'd1,
        ARB_ISSUE    = 3'd2,
        ARB_ACCEPT   = 3'd3,
        ARB_WAIT     = 3'd4,
        ARB_COMPLETE = 3'd5
    } arb_state_e;

    typedef enum logic [1:0] {
        CTL_BOOT = 2'd0,
        CTL_IDLE = 2'd1,
        CTL_BUSY = 2'd2,
        CTL_DONE = 2'd3
    } ctl_state_e;

endpackage

// File: rtl/psram_arb_pick.sv
// Combinational winner select: port 0 first unless the starve limit is hit,
// ports 1 and 2 alternate through the round-robin pointer.
module psram_arb_pick
    import psram_pkg::*;
(
    input  logic [PSRAM_PORTS-1:0] i_stb,
    input  logic                   i_starve_hit,
    input  logic [1:0]             i_rr_ptr,
    output logic [1:0]             o_winner
);

    logic       low_pend;
    logic [1:0] low_pick;

    always_comb begin
        low_pend = i_stb[1] | i_stb[2];
        if (i_stb[1] && i_stb[2]) begin
            low_pick = i_rr_ptr;
        end else if (i_stb[1]) begin
            low_pick = 2'd1;
        end else begin
            low_pick = 2'd2;
        end

        if (low_pend && (!i_stb[0] || i_starve_hit)) begin
            o_winner = low_pick;
        end else begin
            o_winner = 2'd0;
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// Three-port arbiter in front of a single PSRAM controller; one command in
// flight at a time, command fields held steady until the requester sees done.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_p0_stb,
    input  logic        i_p0_we,
    input  logic [23:0] i_p0_addr,
    input  logic [15:0] i_p0_din,
    output logic        o_p0_done,
    output logic [15:0] o_p0_dout,
    input  logic        i_p1_stb,
    input  logic        i_p1_we,
    input  logic [23:0] i_p1_addr,
    input  logic [15:0] i_p1_din,
    output logic        o_p1_done,
    output logic [15:0] o_p1_dout,
    input  logic        i_p2_stb,
    input  logic        i_p2_we,
    input  logic [23:0] i_p2_addr,
    input  logic [15:0] i_p2_din,
    output logic        o_p2_done,
    output logic [15:0] o_p2_dout,
    output logic        o_mem_stb,
    output logic        o_mem_we,
    output logic [23:0] o_mem_addr,
    output logic [15:0] o_mem_din,
    input  logic        i_mem_busy,
    input  logic        i_mem_done,
    input  logic [15:0] i_mem_dout,
    output logic [1:0]  o_grant,
    output logic [2:0]  o_state
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e                        state_q, state_d;
    logic                              mem_we_q, mem_we_d;
    logic [23:0]                       mem_addr_q, mem_addr_d;
    logic [15:0]                       mem_din_q, mem_din_d;
    logic [1:0]                        grant_q, grant_d;
    logic [SW-1:0]                     starve_q, starve_d;
    logic [1:0]                        rr_q, rr_d;
    logic [PSRAM_PORTS-1:0][15:0]      dout_q, dout_d;

    logic [PSRAM_PORTS-1:0]            stb_v, we_v, done_v;
    logic [PSRAM_PORTS-1:0][23:0]      addr_v;
    logic [PSRAM_PORTS-1:0][15:0]      din_v;
    logic [1:0]                        winner;
    logic                              starve_hit, low_pend;
    logic                              win_we;
    logic [23:0]                       win_addr;
    logic [15:0]                       win_din;

    assign stb_v  = {i_p2_stb, i_p1_stb, i_p0_stb};
    assign we_v   = {i_p2_we, i_p1_we, i_p0_we};
    assign addr_v = {i_p2_addr, i_p1_addr, i_p0_addr};
    assign din_v  = {i_p2_din, i_p1_din, i_p0_din};

    assign starve_hit = (starve_q == SW'(STARVE_LIMIT));
    assign low_pend   = stb_v[1] | stb_v[2];

    psram_arb_pick u_pick (
        .i_stb        (stb_v),
        .i_starve_hit (starve_hit),
        .i_rr_ptr     (rr_q),
        .o_winner     (winner)
    );

    always_comb begin
        win_we   = 1'b0;
        win_addr = '0;
        win_din  = '0;
        for (int i = 0; i < PSRAM_PORTS; i++) begin
            if (winner == 2'(i)) begin
                win_we   = we_v[i];
                win_addr = addr_v[i];
                win_din  = din_v[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        grant_d    = grant_q;
        starve_d   = starve_q;
        rr_d       = rr_q;
        dout_d     = dout_q;

        case (state_q)
            ARB_INIT: begin
                if (i_mem_done && !i_mem_busy) state_d = ARB_IDLE;
            end
            ARB_IDLE: begin
                grant_d = GRANT_NONE;
                if (!low_pend) starve_d = '0;
                if (|stb_v) begin
                    mem_we_d   = win_we;
                    mem_addr_d = win_addr;
                    mem_din_d  = win_din;
                    grant_d    = winner;
                    state_d    = ARB_ISSUE;
                    // Only port-0 wins that bypass a waiting low port count toward starvation.
                    if (winner == 2'd0) begin
                        if (low_pend && !starve_hit) starve_d = starve_q + SW'(1);
                    end else begin
                        starve_d = '0;
                        rr_d     = (winner == 2'd1) ? 2'd2 : 2'd1;
                    end
                end
            end
            ARB_ISSUE:  state_d = ARB_ACCEPT;
            ARB_ACCEPT: begin
                if (i_mem_busy) state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (!i_mem_busy && i_mem_done) begin
                    if (!mem_we_q) begin
                        for (int i = 0; i < PSRAM_PORTS; i++) begin
                            if (grant_q == 2'(i)) dout_d[i] = i_mem_dout;
                        end
                    end
                    state_d = ARB_COMPLETE;
                end
            end
            ARB_COMPLETE: begin
                grant_d = GRANT_NONE;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ARB_INIT;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            grant_q    <= GRANT_NONE;
            starve_q   <= '0;
            rr_q       <= 2'd1;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            grant_q    <= grant_d;
            starve_q   <= starve_d;
            rr_q       <= rr_d;
            dout_q     <= dout_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PSRAM_PORTS; gi++) begin : g_done
            assign done_v[gi] = (state_q == ARB_COMPLETE) && (grant_q == 2'(gi));
        end
    endgenerate

    assign o_p0_done  = done_v[0];
    assign o_p1_done  = done_v[1];
    assign o_p2_done  = done_v[2];
    assign o_p0_dout  = dout_q[0];
    assign o_p1_dout  = dout_q[1];
    assign o_p2_dout  = dout_q[2];
    assign o_mem_stb  = (state_q == ARB_ISSUE);
    assign o_mem_we   = mem_we_q;
    assign o_mem_addr = mem_addr_q;
    assign o_mem_din  = mem_din_q;
    assign o_grant    = grant_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: controller model, three requesters, and a scoreboard
// fed from a priority/memory reference model.
module tb_psram_arbiter;
    import psram_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit          stb_r [3];
    logic        we_r  [3];
    logic [23:0] addr_r[3];
    logic [15:0] din_r [3];
    logic        mem_busy, mem_done;
    logic [15:0] mem_dout;

    logic        o_p0_done, o_p1_done, o_p2_done;
    logic [15:0] o_p0_dout, o_p1_dout, o_p2_dout;
    logic        o_mem_stb, o_mem_we;
    logic [23:0] o_mem_addr;
    logic [15:0] o_mem_din;
    logic [1:0]  o_grant;
    logic [2:0]  o_state;

    psram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_p0_stb(stb_r[0]), .i_p0_we(we_r[0]), .i_p0_addr(addr_r[0]), .i_p0_din(din_r[0]),
        .o_p0_done(o_p0_done), .o_p0_dout(o_p0_dout),
        .i_p1_stb(stb_r[1]), .i_p1_we(we_r[1]), .i_p1_addr(addr_r[1]), .i_p1_din(din_r[1]),
        .o_p1_done(o_p1_done), .o_p1_dout(o_p1_dout),
        .i_p2_stb(stb_r[2]), .i_p2_we(we_r[2]), .i_p2_addr(addr_r[2]), .i_p2_din(din_r[2]),
        .o_p2_done(o_p2_done), .o_p2_dout(o_p2_dout),
        .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_din(o_mem_din),
        .i_mem_busy(mem_busy), .i_mem_done(mem_done), .i_mem_dout(mem_dout),
        .o_grant(o_grant), .o_state(o_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    function automatic logic port_done(input int n);
        return (n == 0) ? o_p0_done : (n == 1) ? o_p1_done : o_p2_done;
    endfunction

    function automatic logic [15:0] port_dout(input int n);
        return (n == 0) ? o_p0_dout : (n == 1) ? o_p1_dout : o_p2_dout;
    endfunction

    function automatic logic [15:0] mem_default(input logic [23:0] a);
        return a[15:0] ^ 16'h5A5A ^ {8'h00, a[23:16]};
    endfunction

    // ---------------- controller model ----------------
    logic [15:0] ctrl_mem [logic [23:0]];
    int          boot_cycles = 500;
    int          c_ph, c_cnt;
    logic        c_we;
    logic [23:0] c_addr;
    logic [15:0] c_din;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            c_ph = 0; c_cnt = boot_cycles; mem_busy = 1'b1; mem_done = 1'b0;
        end else begin
            case (c_ph)
                0: if (c_cnt > 0) c_cnt--;
                   else begin c_ph = 1; mem_busy = 1'b0; mem_done = 1'b1; end
                1: if (o_mem_stb) begin
                       c_we = o_mem_we; c_addr = o_mem_addr; c_din = o_mem_din;
                       c_cnt = $urandom_range(0, 2); c_ph = 2;
                   end
                2: if (c_cnt > 0) c_cnt--;
                   else begin
                       mem_busy = 1'b1; mem_done = 1'b0; mem_dout = 16'($urandom);
                       c_cnt = $urandom_range(1, 6); c_ph = 3;
                   end
                default: if (c_cnt > 0) c_cnt--;
                   else begin
                       if (c_we) ctrl_mem[c_addr] = c_din;
                       else mem_dout = ctrl_mem.exists(c_addr) ? ctrl_mem[c_addr] : mem_default(c_addr);
                       mem_busy = 1'b0; mem_done = 1'b1; c_ph = 1;
                   end
            endcase
        end
    end

    // ---------------- requesters ----------------
    bit req_act[3], just_done[3];
    bit rq_rand = 0, rq_drop = 0;
    int rq_rate = 0;

    task automatic new_req(input int n);
        req_act[n] = 1;
        stb_r[n]   = 1;
        we_r[n]    = 1'($urandom_range(0, 1));
        addr_r[n]  = 24'($urandom_range(0, 31));
        din_r[n]   = 16'($urandom);
    endtask

    always @(posedge clk) begin
        #1;
        for (int n = 0; n < 3; n++) begin
            if (rst) begin
                req_act[n] = 0; just_done[n] = 0; stb_r[n] = 0;
            end else if (port_done(n)) begin
                req_act[n] = 0; just_done[n] = 1;
            end else if (just_done[n]) begin
                just_done[n] = 0;
                if (rq_rand && $urandom_range(0, 99) < rq_rate) new_req(n);
                else stb_r[n] = 0;
            end else if (req_act[n]) begin
                if (rq_drop && o_mem_stb && o_grant == 2'(n) && $urandom_range(0, 3) == 0) stb_r[n] = 0;
            end else if (rq_rand && $urandom_range(0, 99) < rq_rate) begin
                new_req(n);
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int          port;
        logic        we;
        logic [23:0] addr;
        logic [15:0] din;
        logic [15:0] rdata;
    } txn_t;

    txn_t        exp_q[$];
    int          grant_log[$];
    logic [15:0] ref_mem [logic [23:0]];
    logic [15:0] exp_dout[3];
    int          ref_streak = 0, ref_last12 = 2;
    bit          cmd_stable;
    int          n_done = 0;
    bit          prev_stb [3];
    logic        prev_we  [3];
    logic [23:0] prev_addr[3];
    logic [15:0] prev_din [3];

    always @(negedge clk) begin : monitor
        int   nd, w, dp;
        bit   pend12;
        txn_t t;
        if (rst) begin
            exp_q.delete();
            ref_streak = 0; ref_last12 = 2;
            for (int i = 0; i < 3; i++) exp_dout[i] = 16'h0;
        end else begin
            nd = int'(o_p0_done) + int'(o_p1_done) + int'(o_p2_done);
            if (o_mem_stb) begin
                check("cmd_while_busy", exp_q.size(), 0);
                // Requests seen in the idle cycle just before the strobe decide the winner.
                pend12 = prev_stb[1] || prev_stb[2];
                if (pend12 && (!prev_stb[0] || ref_streak >= LIMIT))
                    w = (prev_stb[1] && prev_stb[2]) ? ((ref_last12 == 1) ? 2 : 1) : (prev_stb[1] ? 1 : 2);
                else
                    w = 0;
                if (w == 0) ref_streak = pend12 ? ((ref_streak < LIMIT) ? ref_streak + 1 : LIMIT) : 0;
                else begin ref_streak = 0; ref_last12 = w; end
                grant_log.push_back(int'(o_grant));
                check("grant", o_grant, w);
                check("cmd_we", o_mem_we, prev_we[w]);
                check("cmd_addr", o_mem_addr, prev_addr[w]);
                check("cmd_din", o_mem_din, prev_din[w]);
                t.port = w; t.we = prev_we[w]; t.addr = prev_addr[w]; t.din = prev_din[w];
                if (t.we) begin ref_mem[t.addr] = t.din; t.rdata = 16'h0; end
                else t.rdata = ref_mem.exists(t.addr) ? ref_mem[t.addr] : mem_default(t.addr);
                exp_q.push_back(t);
                cmd_stable = 1;
            end else if (exp_q.size() > 0) begin
                if (o_mem_we !== exp_q[0].we || o_mem_addr !== exp_q[0].addr || o_mem_din !== exp_q[0].din)
                    cmd_stable = 0;
            end
            if (nd != 0) begin
                check("done_onehot", nd, 1);
                dp = o_p0_done ? 0 : (o_p1_done ? 1 : 2);
                if (exp_q.size() == 0) begin
                    check("done_without_cmd", exp_q.size(), 1);
                end else begin
                    t = exp_q.pop_front();
                    n_done++;
                    check("done_port", dp, t.port);
                    check("cmd_stable", cmd_stable, 1);
                    if (!t.we) exp_dout[t.port] = t.rdata;
                    check("dout0", o_p0_dout, exp_dout[0]);
                    check("dout1", o_p1_dout, exp_dout[1]);
                    check("dout2", o_p2_dout, exp_dout[2]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            prev_stb[i] = stb_r[i]; prev_we[i] = we_r[i]; prev_addr[i] = addr_r[i]; prev_din[i] = din_r[i];
        end
    end

    // ---------------- directed helpers ----------------
    task automatic issue(input int n, input logic we, input logic [23:0] a, input logic [15:0] d);
        @(posedge clk); #2;
        we_r[n] = we; addr_r[n] = a; din_r[n] = d; req_act[n] = 1; stb_r[n] = 1;
    endtask

    task automatic wait_done(input int n, output int stbs, output int others, output logic [15:0] dout);
        bit ok = 0;
        stbs = 0; others = 0; dout = 16'h0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(posedge clk); #1;
            if (o_mem_stb) stbs++;
            for (int m = 0; m < 3; m++) if (m != n && port_done(m)) others++;
            if (port_done(n)) begin ok = 1; dout = port_dout(n); end
        end
        check($sformatf("p%0d_done_seen", n), ok, 1);
    endtask

    task automatic drain(input string nm);
        bit idle = 0;
        for (int c = 0; c < 600 && !idle; c++) begin
            @(posedge clk); #1;
            idle = !(req_act[0] || req_act[1] || req_act[2]);
        end
        check(nm, idle, 1);
    endtask

    int          order_tbl[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
    int          s, o, cnt;
    bit          found;
    logic [15:0] d;

    initial begin
        for (int i = 0; i < 3; i++) begin
            we_r[i] = 1'b0; addr_r[i] = 24'h0; din_r[i] = 16'h0; stb_r[i] = 0;
        end
        ctrl_mem[24'h00ABCD] = 16'h1234;
        ref_mem[24'h00ABCD]  = 16'h1234;

        // reset values, then a long controller boot
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", o_grant, 2'd3);
        check("rst_state", o_state, ARB_INIT);
        check("rst_mem_stb", o_mem_stb, 1'b0);
        check("rst_mem_fields", {o_mem_we, o_mem_addr, o_mem_din}, 41'h0);
        check("rst_douts", {o_p0_dout, o_p1_dout}, 32'h0);
        check("rst_dout2", o_p2_dout, 16'h0);
        check("rst_dones", {o_p0_done, o_p1_done, o_p2_done}, 3'b000);
        #2 rst = 0;
        issue(0, 1'b0, 24'h000005, 16'h0);
        cnt = 0;
        repeat (480) begin
            @(posedge clk); #1;
            if (o_mem_stb) cnt++;
        end
        check("boot_no_stb", cnt, 0);
        check("boot_state", o_state, ARB_INIT);
        wait_done(0, s, o, d);

        // single port-1 write
        issue(1, 1'b1, 24'h000123, 16'hBEEF);
        wait_done(1, s, o, d);
        check("p1w_stb_count", s, 1);
        check("p1w_other_done", o, 0);

        // port-2 read then write to the same word
        issue(2, 1'b0, 24'h00ABCD, 16'h0);
        wait_done(2, s, o, d);
        check("p2_read_dout", d, 16'h1234);
        issue(2, 1'b1, 24'h00ABCD, 16'h5555);
        wait_done(2, s, o, d);
        repeat (3) @(posedge clk);
        #1 check("p2_dout_held", o_p2_dout, 16'h1234);

        // reset while waiting on the controller
        boot_cycles = 20;
        issue(0, 1'b0, 24'h000007, 16'h0);
        found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(posedge clk); #1;
            if (o_state == ARB_WAIT) found = 1;
        end
        check("reached_wait", found, 1);
        #2 rst = 1;
        @(posedge clk); #1;
        check("midrst_grant", o_grant, 2'd3);
        check("midrst_state", o_state, ARB_INIT);
        check("midrst_done", {o_p0_done, o_p1_done, o_p2_done}, 3'b000);
        #2 rst = 0;
        cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (o_p0_done || o_p1_done || o_p2_done) cnt++;
        end
        check("midrst_no_done", cnt, 0);
        issue(0, 1'b0, 24'h000007, 16'h0);
        wait_done(0, s, o, d);

        // all three ports requesting back-to-back
        @(posedge clk); #2;
        grant_log.delete();
        rq_rate = 100; rq_drop = 0; rq_rand = 1;
        for (int c = 0; c < 500 && grant_log.size() < 10; c++) @(posedge clk);
        #2 rq_rand = 0;
        check("order_len", (grant_log.size() >= 10), 1);
        for (int i = 0; i < 10; i++)
            check($sformatf("order_%0d", i), (i < grant_log.size()) ? grant_log[i] : 99, order_tbl[i]);
        drain("drain_order");

        // random traffic with mid-transaction stb drops
        @(posedge clk); #2;
        n_done = 0;
        rq_rate = 30; rq_drop = 1; rq_rand = 1;
        repeat (3000) @(posedge clk);
        #2 rq_rand = 0;
        drain("drain_random");
        repeat (5) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("random_progress", (n_done > 100), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
